// File: rtl/matvec_pkg.sv
// Shared Q4.12 matvec types and constants: element width, fraction bits,
// saturation limits and the result-collector state encoding.
package matvec_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned FRAC_BITS  = 12;

  localparam logic signed [DATA_WIDTH-1:0] Q412_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] Q412_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DRAIN,
    ST_DONE
  } mv_state_e;

endpackage

// File: rtl/q412_sat_add.sv
// Q4.12 add at one extra bit of width, clamped back to the element range.
module q412_sat_add
  import matvec_pkg::*;
(
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  output logic signed [DATA_WIDTH-1:0] o_sum,
  output logic                         o_sat
);

  logic signed [DATA_WIDTH:0] w_wide;

  assign w_wide = {i_a[DATA_WIDTH-1], i_a} + {i_b[DATA_WIDTH-1], i_b};

  // Top two bits disagree exactly when the sum left the 16-bit range.
  assign o_sat = w_wide[DATA_WIDTH] ^ w_wide[DATA_WIDTH-1];
  assign o_sum = !o_sat ? w_wide[DATA_WIDTH-1:0]
               : (w_wide[DATA_WIDTH] ? Q412_MIN : Q412_MAX);

endmodule

// File: rtl/matvec_result_collector.sv
// Collects per-row matvec results (optionally + bias, saturated) and streams
// them out in BANDWIDTH-lane chunks. Define BIAS_ADD_EN to build the bias store.
module matvec_result_collector
  import matvec_pkg::*;
#(
  parameter int unsigned MAX_ROWS   = 64,
  parameter int unsigned BANDWIDTH  = 4,
  parameter int unsigned DATA_WIDTH = matvec_pkg::DATA_WIDTH
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [$clog2(MAX_ROWS):0]                   num_rows,
  input  logic signed [DATA_WIDTH-1:0]                result_in,
  input  logic                                        result_valid,
  input  logic                                        bias_write_enable,
  input  logic [$clog2(MAX_ROWS)-1:0]                 bias_addr,
  input  logic signed [DATA_WIDTH-1:0]                bias_in,
  output logic signed [BANDWIDTH-1:0][DATA_WIDTH-1:0] chunk_out,
  output logic [$clog2(MAX_ROWS)-1:0]                 chunk_base_addr,
  output logic                                        chunk_valid,
  input  logic                                        chunk_ready,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        sat_flag,
  output logic                                        drop_flag
);

  localparam int unsigned ADDR_W = $clog2(MAX_ROWS);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  mv_state_e r_state, w_state_next;

  logic [CNT_W-1:0] r_num_rows;
  logic [CNT_W-1:0] r_row_cnt;
  logic [CNT_W-1:0] r_chunk_idx, w_chunk_idx_next;

  logic signed [DATA_WIDTH-1:0] r_rows [MAX_ROWS];

  logic signed [BANDWIDTH-1:0][DATA_WIDTH-1:0] r_chunk_out, w_lanes;
  logic [ADDR_W-1:0] r_chunk_base;
  logic r_chunk_valid, r_busy, r_done, r_sat, r_drop;

  logic w_beat, w_last_beat, w_xfer, w_last_chunk;
  logic signed [DATA_WIDTH-1:0] w_add_b, w_store_val;
  logic w_add_sat, w_store_sat;

  function automatic logic [31:0] lane_row(input logic [CNT_W-1:0] idx, input int unsigned lane);
    return 32'(idx) * BANDWIDTH + lane;
  endfunction

  assign w_beat       = (r_state == ST_COLLECT) && result_valid && !start;
  assign w_last_beat  = w_beat && ((r_row_cnt + CNT_W'(1)) == r_num_rows);
  assign w_xfer       = r_chunk_valid && chunk_ready;
  assign w_last_chunk = (32'(r_chunk_idx) + 32'd1) * BANDWIDTH >= 32'(r_num_rows);

`ifdef BIAS_ADD_EN
  logic signed [DATA_WIDTH-1:0] r_bias [MAX_ROWS];

  // Bias store survives reset; a same-cycle write is seen only by later reads.
  always_ff @(posedge clk) begin
    if (bias_write_enable) r_bias[bias_addr] <= bias_in;
  end

  assign w_add_b     = r_bias[r_row_cnt[ADDR_W-1:0]];
  assign w_store_sat = w_add_sat;
`else
  logic w_unused_bias;

  assign w_add_b       = '0;
  assign w_store_sat   = 1'b0;
  assign w_unused_bias = ^{bias_write_enable, bias_addr, bias_in, w_add_sat};
`endif

  q412_sat_add u_sat_add (
    .i_a   (result_in),
    .i_b   (w_add_b),
    .o_sum (w_store_val),
    .o_sat (w_add_sat)
  );

  always_ff @(posedge clk) begin
    if (w_beat && (32'(r_row_cnt) < MAX_ROWS)) r_rows[r_row_cnt[ADDR_W-1:0]] <= w_store_val;
  end

  // Next state; start restarts from any state.
  always_comb begin
    w_state_next     = r_state;
    w_chunk_idx_next = r_chunk_idx;
    if (start) begin
      w_state_next     = (num_rows == '0) ? ST_DONE : ST_COLLECT;
      w_chunk_idx_next = '0;
    end else begin
      case (r_state)
        ST_IDLE:    w_state_next = ST_IDLE;
        ST_COLLECT: if (w_last_beat) w_state_next = ST_DRAIN;
        ST_DRAIN: begin
          if (w_xfer) begin
            if (w_last_chunk) w_state_next = ST_DONE;
            else w_chunk_idx_next = r_chunk_idx + CNT_W'(1);
          end
        end
        ST_DONE:    w_state_next = ST_IDLE;
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  // Lanes of the next chunk; the final beat bypasses the row store.
  always_comb begin
    w_lanes = '0;
    for (int unsigned i = 0; i < BANDWIDTH; i++) begin
      if (lane_row(w_chunk_idx_next, i) < 32'(r_num_rows)) begin
        if (w_beat && (ADDR_W'(lane_row(w_chunk_idx_next, i)) == r_row_cnt[ADDR_W-1:0]))
          w_lanes[i] = w_store_val;
        else
          w_lanes[i] = r_rows[ADDR_W'(lane_row(w_chunk_idx_next, i))];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_num_rows    <= '0;
      r_row_cnt     <= '0;
      r_chunk_idx   <= '0;
      r_chunk_out   <= '0;
      r_chunk_base  <= '0;
      r_chunk_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_sat         <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_chunk_idx <= w_chunk_idx_next;
      if (start) begin
        r_num_rows <= num_rows;
        r_row_cnt  <= '0;
        r_sat      <= 1'b0;
        r_drop     <= 1'b0;
      end else begin
        if (w_beat) r_row_cnt <= r_row_cnt + CNT_W'(1);
        if (w_beat && w_store_sat) r_sat <= 1'b1;
        if (result_valid && (r_state != ST_COLLECT)) r_drop <= 1'b1;
      end
      r_chunk_valid <= (w_state_next == ST_DRAIN);
      r_busy        <= (w_state_next == ST_COLLECT) || (w_state_next == ST_DRAIN);
      r_done        <= (w_state_next == ST_DONE);
      r_chunk_out   <= (w_state_next == ST_DRAIN) ? w_lanes : '0;
      r_chunk_base  <= (w_state_next == ST_DRAIN) ? ADDR_W'(32'(w_chunk_idx_next) * BANDWIDTH) : '0;
    end
  end

  assign chunk_out       = r_chunk_out;
  assign chunk_base_addr = r_chunk_base;
  assign chunk_valid     = r_chunk_valid;
  assign busy            = r_busy;
  assign done            = r_done;
  assign sat_flag        = r_sat;
  assign drop_flag       = r_drop;

endmodule
